// File: rtl/demux3_dispatch_pkg.sv
// Shared CPU datapath constants: channel select encodings and default word width.
package demux3_dispatch_pkg;

   localparam int unsigned DEFAULT_WIDTH = 32;
   localparam int unsigned NUM_CH        = 3;

   typedef enum logic [1:0] {
      SEL_CH0 = 2'b00,
      SEL_CH1 = 2'b01,
      SEL_CH2 = 2'b10,
      SEL_ERR = 2'b11
   } sel_e;

   // One-hot channel mask for a select; the error code maps to no channel.
   function automatic logic [NUM_CH-1:0] sel_onehot(input sel_e sel);
      logic [NUM_CH-1:0] mask;
      mask = '0;
      case (sel)
         SEL_CH0: mask = 3'b001;
         SEL_CH1: mask = 3'b010;
         SEL_CH2: mask = 3'b100;
         default: mask = 3'b000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/demux3_dispatch_sync_fifo.sv
// Synchronous in-order FIFO with extra-MSB pointers; head entry is visible on rdata_o.
module sync_fifo #(
   parameter int unsigned WIDTH = 34,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW:0]      wr_q, wr_d;
   logic [AW:0]      rd_q, rd_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign rdata_o = mem_q[rd_q[AW-1:0]];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (do_push) wr_d = wr_q + (AW+1)'(1);
      if (do_pop)  rd_d = rd_q + (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Storage needs no reset: entries are only read between push and pop.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/demux3_dispatch.sv
// Registered 1-to-3 word distributor: in-order FIFO feeding three held output channels,
// with error-select entries dropped and counted.
module demux3_dispatch
   import demux3_dispatch_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned ERR_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_sel,
   output logic [2:0]       out_valid,
   input  logic [2:0]       out_ready,
   output logic [WIDTH-1:0] out_data0,
   output logic [WIDTH-1:0] out_data1,
   output logic [WIDTH-1:0] out_data2,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_cnt
);

   localparam int unsigned EW = WIDTH + 2;

   logic [EW-1:0]    head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             push;
   logic             pop;
   sel_e             head_sel;
   logic [WIDTH-1:0] head_data;
   logic [2:0]       slot_free;
   logic [2:0]       load;

   logic [2:0]       valid_q, valid_d;
   logic [WIDTH-1:0] data0_q, data0_d;
   logic [WIDTH-1:0] data1_q, data1_d;
   logic [WIDTH-1:0] data2_q, data2_d;
   logic             err_pulse_q, err_pulse_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

   assign in_ready = ~fifo_full;
   assign push     = in_valid & ~fifo_full;

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .wdata_i ({in_sel, in_data}),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign head_sel  = sel_e'(head[EW-1 -: 2]);
   assign head_data = head[WIDTH-1:0];
   assign slot_free = ~valid_q | out_ready;

   // Head pops when its channel slot is free, or always for the error code.
   assign pop  = ~fifo_empty & ((head_sel == SEL_ERR) | (|(sel_onehot(head_sel) & slot_free)));
   assign load = pop ? sel_onehot(head_sel) : 3'b000;

   always_comb begin
      valid_d     = (valid_q & ~out_ready) | load;
      data0_d     = data0_q;
      data1_d     = data1_q;
      data2_d     = data2_q;
      err_pulse_d = pop & (head_sel == SEL_ERR);
      err_cnt_d   = err_cnt_q;
      if (load[0]) data0_d = head_data;
      if (load[1]) data1_d = head_data;
      if (load[2]) data2_d = head_data;
      if (err_pulse_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q     <= '0;
         data0_q     <= '0;
         data1_q     <= '0;
         data2_q     <= '0;
         err_pulse_q <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         valid_q     <= valid_d;
         data0_q     <= data0_d;
         data1_q     <= data1_d;
         data2_q     <= data2_d;
         err_pulse_q <= err_pulse_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data0 = data0_q;
   assign out_data1 = data1_q;
   assign out_data2 = data2_q;
   assign err_pulse = err_pulse_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_demux3_dispatch.sv
// Directed bench for demux3_dispatch with hand-computed expected values.
module tb_demux3_dispatch;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [1:0]  in_sel;
   logic [2:0]  out_valid;
   logic [2:0]  out_ready;
   logic [31:0] out_data0;
   logic [31:0] out_data1;
   logic [31:0] out_data2;
   logic        err_pulse;
   logic [7:0]  err_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   demux3_dispatch #(
      .WIDTH (32),
      .DEPTH (2),
      .ERR_W (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data0 (out_data0),
      .out_data1 (out_data1),
      .out_data2 (out_data2),
      .err_pulse (err_pulse),
      .err_cnt   (err_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle; inputs are driven and outputs sampled here.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d);
      in_valid = v;
      in_sel   = s;
      in_data  = d;
   endtask

   initial begin
      reset     = 1'b1;
      out_ready = 3'b111;
      drive(1'b0, 2'b00, 32'h0);
      step();
      step();
      reset = 1'b0;
      step();

      // Reset state
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_data0", out_data0, 32'h0);
      check("rst_data1", out_data1, 32'h0);
      check("rst_errcnt", 32'(err_cnt), 32'h0);
      check("rst_errpulse", 32'(err_pulse), 32'h0);
      check("rst_inready", 32'(in_ready), 32'h1);

      // Single word to ch1: valid two edges after acceptance
      drive(1'b1, 2'b01, 32'h1234_5678);
      step();
      drive(1'b0, 2'b00, 32'h0);
      check("s1_not_yet", 32'(out_valid), 32'h0);
      step();
      check("s1_valid", 32'(out_valid), 32'h2);
      check("s1_data1", out_data1, 32'h1234_5678);
      step();
      check("s1_clear", 32'(out_valid), 32'h0);
      check("s1_retain", out_data1, 32'h1234_5678);

      // Back-to-back 00,01,10,00, no bubbles
      drive(1'b1, 2'b00, 32'hA0);
      step();
      drive(1'b1, 2'b01, 32'hA1);
      step();
      check("b2b_v0", 32'(out_valid), 32'h1);
      check("b2b_d0", out_data0, 32'hA0);
      check("b2b_rdy0", 32'(in_ready), 32'h1);
      drive(1'b1, 2'b10, 32'hA2);
      step();
      check("b2b_v1", 32'(out_valid), 32'h2);
      check("b2b_d1", out_data1, 32'hA1);
      check("b2b_rdy1", 32'(in_ready), 32'h1);
      drive(1'b1, 2'b00, 32'hA3);
      step();
      check("b2b_v2", 32'(out_valid), 32'h4);
      check("b2b_d2", out_data2, 32'hA2);
      check("b2b_rdy2", 32'(in_ready), 32'h1);
      drive(1'b0, 2'b00, 32'h0);
      step();
      check("b2b_v3", 32'(out_valid), 32'h1);
      check("b2b_d3", out_data0, 32'hA3);
      step();
      check("b2b_idle", 32'(out_valid), 32'h0);

      // Backpressure on ch0 blocks an in-order later ch2 word
      out_ready = 3'b110;
      drive(1'b1, 2'b00, 32'hB0);
      step();
      drive(1'b1, 2'b00, 32'hB1);
      step();
      check("bp_v0", 32'(out_valid), 32'h1);
      check("bp_d0", out_data0, 32'hB0);
      drive(1'b1, 2'b10, 32'hB2);
      step();
      drive(1'b0, 2'b00, 32'h0);
      check("bp_full", 32'(in_ready), 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("bp_hold_v", 32'(out_valid), 32'h1);
         check("bp_hold_d", out_data0, 32'hB0);
         check("bp_hold_d2", out_data2, 32'hA2);
         check("bp_hold_rdy", 32'(in_ready), 32'h0);
      end
      out_ready = 3'b111;
      step();
      check("bp_rel_v", 32'(out_valid), 32'h1);
      check("bp_rel_d", out_data0, 32'hB1);
      check("bp_rel_rdy", 32'(in_ready), 32'h1);
      step();
      check("bp_b2_v", 32'(out_valid), 32'h4);
      check("bp_b2_d", out_data2, 32'hB2);
      step();
      check("bp_idle", 32'(out_valid), 32'h0);

      // Error entry between two good words
      drive(1'b1, 2'b00, 32'hC0);
      step();
      drive(1'b1, 2'b11, 32'hDEAD);
      step();
      check("err_c0_v", 32'(out_valid), 32'h1);
      check("err_c0_d", out_data0, 32'hC0);
      check("err_pre_pulse", 32'(err_pulse), 32'h0);
      drive(1'b1, 2'b01, 32'hC1);
      step();
      drive(1'b0, 2'b00, 32'h0);
      check("err_pulse", 32'(err_pulse), 32'h1);
      check("err_cnt1", 32'(err_cnt), 32'h1);
      check("err_nov", 32'(out_valid), 32'h0);
      step();
      check("err_pulse_off", 32'(err_pulse), 32'h0);
      check("err_c1_v", 32'(out_valid), 32'h2);
      check("err_c1_d", out_data1, 32'hC1);
      check("err_d0_keep", out_data0, 32'hC0);
      check("err_d2_keep", out_data2, 32'hB2);
      check("err_cnt1_hold", 32'(err_cnt), 32'h1);

      // 300 more error entries: counter climbs then saturates
      drive(1'b1, 2'b11, 32'hEEEE);
      for (int k = 1; k <= 300; k++) begin
         step();
         if (k == 100) check("err_cnt_mid", 32'(err_cnt), 32'd100);
      end
      drive(1'b0, 2'b00, 32'h0);
      step();
      step();
      check("err_sat", 32'(err_cnt), 32'hFF);
      check("err_sat_nov", 32'(out_valid), 32'h0);

      // Ch2 consumed and refilled in the same cycle
      drive(1'b1, 2'b10, 32'hD0);
      step();
      drive(1'b1, 2'b10, 32'hD1);
      step();
      drive(1'b0, 2'b00, 32'h0);
      check("rf_v0", 32'(out_valid), 32'h4);
      check("rf_d0", out_data2, 32'hD0);
      step();
      check("rf_v1", 32'(out_valid), 32'h4);
      check("rf_d1", out_data2, 32'hD1);
      step();
      check("rf_idle", 32'(out_valid), 32'h0);

      // Fill FIFO and all channels, then reset mid-operation
      out_ready = 3'b000;
      drive(1'b1, 2'b00, 32'hE0);
      step();
      drive(1'b1, 2'b01, 32'hE1);
      step();
      drive(1'b1, 2'b10, 32'hE2);
      step();
      drive(1'b1, 2'b00, 32'hE3);
      step();
      drive(1'b1, 2'b01, 32'hE4);
      step();
      check("fill_v", 32'(out_valid), 32'h7);
      check("fill_rdy", 32'(in_ready), 32'h0);
      check("fill_d1", out_data1, 32'hE1);
      reset     = 1'b1;
      out_ready = 3'b111;
      step();
      reset = 1'b0;
      drive(1'b0, 2'b00, 32'h0);
      check("mrst_v", 32'(out_valid), 32'h0);
      check("mrst_cnt", 32'(err_cnt), 32'h0);
      check("mrst_rdy", 32'(in_ready), 32'h1);
      check("mrst_d2", out_data2, 32'h0);
      step();
      check("mrst_empty_v", 32'(out_valid), 32'h0);
      drive(1'b1, 2'b01, 32'hF0);
      step();
      drive(1'b0, 2'b00, 32'h0);
      step();
      check("post_v", 32'(out_valid), 32'h2);
      check("post_d1", out_data1, 32'hF0);
      step();
      check("post_idle", 32'(out_valid), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
